cordic_job_sequencer: RTL and testbench

//  Request/response front end for the CORDIC cosine core. Buffers float angles from a valid/ready

---
 rtl/cordic_job_sequencer_if.sv | 28 ++
 rtl/cordic_job_sequencer.sv | 139 +++++++++++++
 tb/tb_cordic_job_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/cordic_job_sequencer_if.sv
// Handshake bundle for the CORDIC job sequencer: producer, consumer and core pins.
// The master modport is the environment side and the slave modport is the sequencer side.
interface cordic_job_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_angle;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_result;
    logic                  out_timeout;
    logic                  cordic_en;
    logic [DATA_WIDTH-1:0] cordic_angle;
    logic [DATA_WIDTH-1:0] cordic_result;
    logic                  cordic_done;
    logic                  busy;

    modport master (
        output in_valid, in_angle, out_ready, cordic_result, cordic_done,
        input  in_ready, out_valid, out_result, out_timeout, cordic_en, cordic_angle, busy
    );

    modport slave (
        input  in_valid, in_angle, out_ready, cordic_result, cordic_done,
        output in_ready, out_valid, out_result, out_timeout, cordic_en, cordic_angle, busy
    );
endinterface

// File: rtl/cordic_job_sequencer.sv
// Front end for the CORDIC cosine core: input FIFO, one-job-at-a-time issue FSM with watchdog,
// and an output FIFO carrying the result plus a timeout flag.
//
// state   | meaning
// IDLE    | waiting for a queued angle and a free output slot
// ISSUE   | core enabled on a held angle, waiting for done or watchdog expiry
// RELEASE | core disabled, waiting for done to fall before the next job
module cordic_job_sequencer #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    IN_DEPTH_LOG2  = 2,
    parameter int                    OUT_DEPTH_LOG2 = 2,
    parameter int                    TIMEOUT        = 63,
    parameter logic [DATA_WIDTH-1:0] NAN_WORD       = 32'h7FC00000
) (
    input logic                    clk,
    input logic                    rst,
    cordic_job_sequencer_if.slave  bus
);
    localparam int IN_D  = 1 << IN_DEPTH_LOG2;
    localparam int OUT_D = 1 << OUT_DEPTH_LOG2;
    localparam logic [IN_DEPTH_LOG2:0]  IN_FULL  = (IN_DEPTH_LOG2 + 1)'(IN_D);
    localparam logic [OUT_DEPTH_LOG2:0] OUT_FULL = (OUT_DEPTH_LOG2 + 1)'(OUT_D);
    localparam logic [7:0]              WD_LIMIT = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

    state_t state;

    logic [DATA_WIDTH-1:0]     in_mem [IN_D];
    logic [IN_DEPTH_LOG2-1:0]  in_wr, in_rd;
    logic [IN_DEPTH_LOG2:0]    in_count;

    logic [DATA_WIDTH-1:0]     out_mem [OUT_D];
    logic                      out_to_mem [OUT_D];
    logic [OUT_DEPTH_LOG2-1:0] out_wr, out_rd;
    logic [OUT_DEPTH_LOG2:0]   out_count;

    logic [7:0]                watchdog;
    logic                      done_q;
    logic                      cordic_en_r;
    logic [DATA_WIDTH-1:0]     cordic_angle_r;

    logic in_full, in_empty, in_push, in_pop;
    logic out_empty, out_push, out_pop, out_push_to;
    logic done_rise, job_done, job_timeout, issue;
    logic [DATA_WIDTH-1:0] out_push_data;

    assign in_full   = (in_count == IN_FULL);
    assign in_empty  = (in_count == '0);
    assign in_push   = bus.in_valid & ~in_full;
    // No job is in flight while IDLE, so one free output slot is enough credit.
    assign issue     = (state == IDLE) & ~in_empty & (out_count < OUT_FULL);
    assign in_pop    = issue;

    assign out_empty   = (out_count == '0);
    assign out_pop     = ~out_empty & bus.out_ready;
    assign done_rise   = bus.cordic_done & ~done_q;
    assign job_done    = (state == ISSUE) & done_rise;
    assign job_timeout = (state == ISSUE) & ~done_rise & (watchdog == WD_LIMIT);
    assign out_push    = job_done | job_timeout;
    assign out_push_to = job_timeout;
    assign out_push_data = job_done ? bus.cordic_result : NAN_WORD;

    assign bus.in_ready     = ~in_full;
    assign bus.out_valid    = ~out_empty;
    assign bus.out_result   = out_empty ? '0 : out_mem[out_rd];
    assign bus.out_timeout  = out_empty ? 1'b0 : out_to_mem[out_rd];
    assign bus.cordic_en    = cordic_en_r;
    assign bus.cordic_angle = cordic_angle_r;
    assign bus.busy         = (state != IDLE) | ~in_empty | ~out_empty;

    always_ff @(posedge clk) begin
        if (in_push) in_mem[in_wr] <= bus.in_angle;
        if (out_push) begin
            out_mem[out_wr]    <= out_push_data;
            out_to_mem[out_wr] <= out_push_to;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_wr     <= '0;
            in_rd     <= '0;
            in_count  <= '0;
            out_wr    <= '0;
            out_rd    <= '0;
            out_count <= '0;
        end else begin
            if (in_push)  in_wr  <= in_wr + 1'b1;
            if (in_pop)   in_rd  <= in_rd + 1'b1;
            if (out_push) out_wr <= out_wr + 1'b1;
            if (out_pop)  out_rd <= out_rd + 1'b1;
            case ({in_push, in_pop})
                2'b10:   in_count <= in_count + 1'b1;
                2'b01:   in_count <= in_count - 1'b1;
                default: in_count <= in_count;
            endcase
            case ({out_push, out_pop})
                2'b10:   out_count <= out_count + 1'b1;
                2'b01:   out_count <= out_count - 1'b1;
                default: out_count <= out_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cordic_en_r    <= 1'b0;
            cordic_angle_r <= '0;
            watchdog       <= '0;
            done_q         <= 1'b0;
        end else begin
            done_q <= bus.cordic_done;
            case (state)
                IDLE: begin
                    if (issue) begin
                        cordic_angle_r <= in_mem[in_rd];
                        cordic_en_r    <= 1'b1;
                        watchdog       <= '0;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    watchdog <= watchdog + 1'b1;
                    if (out_push) begin
                        cordic_en_r <= 1'b0;
                        state       <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Guarantees the core sees clk_en low and done low before the next job.
                    if (!bus.cordic_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_job_sequencer.sv
// Scoreboard bench for cordic_job_sequencer with a behavioural CORDIC core model.
module tb_cordic_job_sequencer;
    localparam int          DW       = 32;
    localparam int          TIMEOUT  = 63;
    localparam logic [31:0] NAN_WORD = 32'h7FC00000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cordic_job_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    cordic_job_sequencer #(
        .DATA_WIDTH(DW), .IN_DEPTH_LOG2(2), .OUT_DEPTH_LOG2(2),
        .TIMEOUT(TIMEOUT), .NAN_WORD(NAN_WORD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q [$];

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] cos_model(input logic [31:0] a);
        case (a)
            32'h00000000: return 32'h3F800000;
            32'h3F490FD8: return 32'h3F3504F3;
            default:      return a ^ 32'h5A5A5A5A;
        endcase
    endfunction

    // Core model: done rises 3 cycles after clk_en rises and stays high 2 cycles.
    logic model_hang = 1'b0;
    logic job_seen   = 1'b0;
    int   mcnt       = 0;
    initial begin
        bus.cordic_done   = 1'b0;
        bus.cordic_result = '0;
    end
    always @(negedge clk) begin
        if (rst) begin
            job_seen = 1'b0;
            mcnt = 0;
            bus.cordic_done = 1'b0;
        end else if (!job_seen && bus.cordic_en) begin
            job_seen = 1'b1;
            mcnt = 0;
        end else if (job_seen) begin
            mcnt++;
            if (mcnt == 3 && !model_hang) begin
                bus.cordic_done   = 1'b1;
                bus.cordic_result = cos_model(bus.cordic_angle);
            end
            if (mcnt == 5) bus.cordic_done = 1'b0;
            if (mcnt > 5 && !bus.cordic_en) job_seen = 1'b0;
        end
    end

    // Observers for enable timing, angle stability and back-pressure.
    int   jobs_issued = 0;
    int   en_run = 0, last_run = 0;
    int   gap = 0, min_gap = 1000;
    int   stable_err = 0;
    logic saw_not_ready = 1'b0;
    logic prev_en = 1'b0;
    logic [31:0] prev_angle = '0;
    always @(negedge clk) begin
        #1;
        if (bus.cordic_en && !prev_en) begin
            if (jobs_issued > 0 && gap < min_gap) min_gap = gap;
            jobs_issued++;
            gap = 0;
        end
        if (bus.cordic_en) en_run++;
        else begin
            if (prev_en) begin
                last_run = en_run;
                en_run = 0;
            end
            gap++;
        end
        if (bus.cordic_en && prev_en && bus.cordic_angle !== prev_angle) stable_err++;
        if (bus.in_valid && !bus.in_ready) saw_not_ready = 1'b1;
        prev_en = bus.cordic_en;
        prev_angle = bus.cordic_angle;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check_val("unexpected_out", 64'd1, 64'd0);
            else check_val("out_word", {31'd0, bus.out_timeout, bus.out_result}, exp_q.pop_front());
        end
    end

    task automatic send(input logic [31:0] a, input logic to);
        bus.in_valid = 1'b1;
        bus.in_angle = a;
        for (int i = 0; i < 400; i++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                exp_q.push_back({31'd0, to, to ? NAN_WORD : cos_model(a)});
                @(negedge clk);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        check_val("send_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 600; i++) begin
            if (exp_q.size() == 0 && !bus.busy) return;
            @(negedge clk);
        end
        check_val(tag, 64'd0, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    int j0;
    initial begin
        bus.in_valid  = 1'b0;
        bus.in_angle  = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        check_val("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check_val("rst_busy",      {63'd0, bus.busy},      64'd0);
        check_val("rst_en",        {63'd0, bus.cordic_en}, 64'd0);
        check_val("rst_angle",     {32'd0, bus.cordic_angle}, 64'd0);
        check_val("rst_result",    {31'd0, bus.out_timeout, bus.out_result}, 64'd0);

        // Single job, zero angle.
        j0 = jobs_issued;
        send(32'h00000000, 1'b0);
        drain("t1_drain");
        check_val("t1_jobs", 64'(jobs_issued - j0), 64'd1);
        check_val("t1_en_low", {63'd0, bus.cordic_en}, 64'd0);

        // Second job; enable must have been low before it.
        send(32'h3F490FD8, 1'b0);
        drain("t2_drain");
        check_val("t2_gap_ok", {63'd0, (min_gap >= 2)}, 64'd1);

        // Six angles with the consumer stalled: credit limits issue to four jobs.
        bus.out_ready = 1'b0;
        saw_not_ready = 1'b0;
        j0 = jobs_issued;
        for (int i = 0; i < 6; i++) send(32'h40000000 + 32'(i), 1'b0);
        repeat (100) @(negedge clk);
        check_val("t3_in_ready_dropped", {63'd0, saw_not_ready}, 64'd1);
        check_val("t3_jobs_stalled", 64'(jobs_issued - j0), 64'd4);
        check_val("t3_out_valid", {63'd0, bus.out_valid}, 64'd1);
        bus.out_ready = 1'b1;
        drain("t3_drain");
        check_val("t3_jobs_all", 64'(jobs_issued - j0), 64'd6);

        // Core never answers: watchdog aborts, then a normal job follows.
        model_hang = 1'b1;
        send(32'h12345678, 1'b1);
        drain("t4_drain");
        check_val("t4_en_len_ok", {63'd0, (last_run >= TIMEOUT && last_run <= TIMEOUT + 1)}, 64'd1);
        model_hang = 1'b0;
        repeat (8) @(negedge clk);
        send(32'h3F490FD8, 1'b0);
        drain("t4_next_drain");

        // Reset during ISSUE drops the job.
        bus.in_valid = 1'b1;
        bus.in_angle = 32'h0BADF00D;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.cordic_en; i++) @(negedge clk);
        check_val("t5_en_seen", {63'd0, bus.cordic_en}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("t5_en_dropped", {63'd0, bus.cordic_en}, 64'd0);
        check_val("t5_out_valid",  {63'd0, bus.out_valid}, 64'd0);
        check_val("t5_busy",       {63'd0, bus.busy},      64'd0);
        check_val("t5_in_ready",   {63'd0, bus.in_ready},  64'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check_val("t5_no_output", {63'd0, bus.out_valid}, 64'd0);
        send(32'h00000000, 1'b0);
        drain("t5_drain");

        // Back-to-back 1..8 keeps the input FIFO full while IDLE pops.
        saw_not_ready = 1'b0;
        j0 = jobs_issued;
        for (int i = 1; i <= 8; i++) send(32'(i), 1'b0);
        drain("t6_drain");
        check_val("t6_full_seen", {63'd0, saw_not_ready}, 64'd1);
        check_val("t6_jobs", 64'(jobs_issued - j0), 64'd8);

        check_val("queue_empty", 64'(exp_q.size()), 64'd0);
        check_val("angle_stable_errs", 64'(stable_err), 64'd0);
        check_val("min_gap_ok", {63'd0, (min_gap >= 2)}, 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
